spi_pkt_tx: RTL and testbench

//  Byte serializer for the SPI packet path; the transmit counterpart of the SPI byte receiver.

---
 rtl/spi_pkt_pkg.sv | 14 +
 rtl/spi_pkt_fifo.sv | 46 ++++
 rtl/spi_pkt_tx.sv | 141 ++++++++++++++
 tb/tb_spi_pkt_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared types and defaults for the SPI packet transmit path.
// Used by spi_pkt_fifo and spi_pkt_tx.
package spi_pkt_pkg;

  localparam int   DATA_W_DEF   = 8;
  localparam int   BUF_DEPTH_DEF = 2;
  localparam logic IDLE_BIT_DEF = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/spi_pkt_fifo.sv
// Holding FIFO for the SPI transmitter, DATA_W x DEPTH.
// First-word fall-through read port, asynchronous reset.
module spi_pkt_fifo
  import spi_pkt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [AW:0]       diff;

  // Extra pointer bit separates full from empty.
  assign diff    = wptr_q - rptr_q;
  assign full_o  = diff[AW];
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_pkt_tx.sv
// SPI packet byte serializer: FIFO-buffered, one bit per en strobe.
// Define SPI_PKT_TX_LSB_FIRST_EN for LSB-first order (default MSB first).
module spi_pkt_tx
  import spi_pkt_pkg::*;
#(
  parameter int   DATA_W    = DATA_W_DEF,
  parameter int   BUF_DEPTH = BUF_DEPTH_DEF,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              en,
  output logic              dout,
  output logic              byte_flg,
  output logic              busy,
  output logic              underrun
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              flg_q, flg_d;
  logic              und_q, und_d;

  logic              f_full;
  logic              f_empty;
  logic [DATA_W-1:0] f_rdata;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sh_next;

  function automatic logic head_bit(
    input logic [DATA_W-1:0] w
  );
`ifdef SPI_PKT_TX_LSB_FIRST_EN
    return w[0];
`else
    return w[DATA_W-1];
`endif
  endfunction

`ifdef SPI_PKT_TX_LSB_FIRST_EN
  assign sh_next = sh_q >> 1;
`else
  assign sh_next = sh_q << 1;
`endif

  assign din_ready = !f_full;
  assign push      = din_valid && !f_full;
  assign busy      = (state_q == ST_SHIFT) || !f_empty;
  assign dout      = dout_q;
  assign byte_flg  = flg_q;
  assign underrun  = und_q;

  spi_pkt_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (din),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    flg_d   = 1'b0;
    und_d   = en && (state_q == ST_IDLE);
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          sh_d    = f_rdata;
          cnt_d   = '0;
          dout_d  = head_bit(f_rdata);
          state_d = ST_SHIFT;
        end else begin
          dout_d  = IDLE_BIT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          if (cnt_q == LAST) begin
            flg_d = 1'b1;
            // f_empty reflects only words present before this edge.
            if (!f_empty) begin
              pop     = 1'b1;
              sh_d    = f_rdata;
              cnt_d   = '0;
              dout_d  = head_bit(f_rdata);
            end else begin
              state_d = ST_IDLE;
              sh_d    = '0;
              cnt_d   = '0;
              dout_d  = IDLE_BIT;
            end
          end else begin
            sh_d   = sh_next;
            cnt_d  = cnt_q + 1'b1;
            dout_d = head_bit(sh_next);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= IDLE_BIT;
      flg_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      flg_q   <= flg_d;
      und_q   <= und_d;
    end
  end

endmodule

// File: tb/tb_spi_pkt_tx.sv
// Self-checking bench for spi_pkt_tx: vector table, cycle model,
// loopback receiver with a byte scoreboard.
module tb_spi_pkt_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       en = 1'b0;
  logic       dout;
  logic       byte_flg;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  spi_pkt_tx dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .en        (en),
    .dout      (dout),
    .byte_flg  (byte_flg),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mq[$];
  logic       mst;
  logic [7:0] mcur;
  int         mcnt;
  logic       mdout, mflg, mund;

  // Scoreboard and loopback receiver
  logic [7:0] sb[$];
  logic [7:0] rx;
  int         flg_cnt;
  int         cycn;
  int         flg_at[$];

  task automatic chk(input string n,
                     input logic [7:0] a,
                     input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               n, a, e, cycn);
    end
  endtask

  function automatic logic mbit(input logic [7:0] w,
                                input int i);
`ifdef SPI_PKT_TX_LSB_FIRST_EN
    return w[i];
`else
    return w[7-i];
`endif
  endfunction

  task automatic mreset();
    mq.delete();
    sb.delete();
    mst = 1'b0; mcur = '0; mcnt = 0;
    mdout = 1'b0; mflg = 1'b0; mund = 1'b0;
    rx = '0;
  endtask

  task automatic mstep(input logic v,
                       input logic [7:0] d,
                       input logic e);
    logic ne, pu;
    ne = (mq.size() > 0);
    pu = v && (mq.size() < 2);
    mund = e && !mst;
    mflg = 1'b0;
    if (!mst) begin
      if (ne) begin
        mcur = mq.pop_front(); mcnt = 0;
        mst = 1'b1; mdout = mbit(mcur, 0);
      end else mdout = 1'b0;
    end else if (e) begin
      if (mcnt == 7) begin
        mflg = 1'b1;
        if (ne) begin
          mcur = mq.pop_front(); mcnt = 0;
          mdout = mbit(mcur, 0);
        end else begin
          mst = 1'b0; mdout = 1'b0;
        end
      end else begin
        mcnt++;
        mdout = mbit(mcur, mcnt);
      end
    end
    if (pu) mq.push_back(d);
  endtask

  task automatic cyc(input logic v,
                     input logic [7:0] d,
                     input logic e);
    logic pre, acc;
    @(negedge clk);
    din_valid = v; din = d; en = e;
    #1;
    pre = dout;
    acc = v && din_ready;
    chk("din_ready_pre", {7'd0, din_ready},
        {7'd0, mq.size() < 2});
    @(posedge clk);
    mstep(v, d, e);
    if (acc) sb.push_back(d);
    #1;
    cycn++;
    chk("dout", {7'd0, dout}, {7'd0, mdout});
    chk("byte_flg", {7'd0, byte_flg}, {7'd0, mflg});
    chk("underrun", {7'd0, underrun}, {7'd0, mund});
    chk("busy", {7'd0, busy},
        {7'd0, mst || (mq.size() > 0)});
    chk("din_ready", {7'd0, din_ready},
        {7'd0, mq.size() < 2});
`ifdef SPI_PKT_TX_LSB_FIRST_EN
    if (e) rx = {pre, rx[7:1]};
`else
    if (e) rx = {rx[6:0], pre};
`endif
    if (byte_flg) begin
      flg_cnt++;
      flg_at.push_back(cycn);
      if (sb.size() == 0) begin
        chk("rx_unexpected", rx, 8'hxx);
      end else begin
        chk("rx_byte", rx, sb.pop_front());
      end
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic       x_dout;
    logic       x_flg;
    logic       x_busy;
  } vec_t;

  vec_t t2[10];
  int   f0, n;

  initial begin
    // A5 is bit-symmetric, so this table holds for either bit order.
    t2[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    t2[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    t2[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    t2[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    t2[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    t2[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    t2[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    t2[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    t2[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    t2[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

    cycn = 0; flg_cnt = 0;
    mreset();
    #12;
    chk("rst_dout", {7'd0, dout}, 8'd0);
    chk("rst_flg", {7'd0, byte_flg}, 8'd0);
    chk("rst_und", {7'd0, underrun}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_rdy", {7'd0, din_ready}, 8'd1);
    @(negedge clk); rst = 1'b0;

    // Idle strobes: underrun every cycle
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("t1_und", {7'd0, underrun}, 8'd1);
    end

    // Table: single byte A5
    for (int i = 0; i < 10; i++) begin
      cyc(t2[i].v, t2[i].d, t2[i].e);
      chk("t2_dout", {7'd0, dout}, {7'd0, t2[i].x_dout});
      chk("t2_flg", {7'd0, byte_flg}, {7'd0, t2[i].x_flg});
      chk("t2_busy", {7'd0, busy}, {7'd0, t2[i].x_busy});
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Back-to-back bytes, no gap
    flg_at.delete();
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 18; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("t3_nflg", 8'(flg_at.size()), 8'd2);
    if (flg_at.size() == 2)
      chk("t3_gap", 8'(flg_at[1] - flg_at[0]), 8'd8);

    // Toggling strobe
    f0 = flg_cnt;
    cyc(1'b1, 8'hF0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 8'h00, (i % 2) == 0);
    chk("t4_flgs", 8'(flg_cnt - f0), 8'd1);

    // Reset mid-byte with a byte queued
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    en = 1'b0; din_valid = 1'b0;
    rst = 1'b1;
    #1;
    mreset();
    chk("t5_dout", {7'd0, dout}, 8'd0);
    chk("t5_busy", {7'd0, busy}, 8'd0);
    chk("t5_rdy", {7'd0, din_ready}, 8'd1);
    chk("t5_flg", {7'd0, byte_flg}, 8'd0);
    chk("t5_und", {7'd0, underrun}, 8'd0);
    @(negedge clk); rst = 1'b0;
    f0 = flg_cnt;
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("t5_noflg", 8'(flg_cnt - f0), 8'd0);

    // Bit order probe
    cyc(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          $urandom_range(0, 3) != 0);

    // Drain with a bounded budget
    n = 0;
    while ((busy || sb.size() > 0) && n < 40) begin
      cyc(1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("drain_busy", {7'd0, busy}, 8'd0);
    chk("drain_sb", 8'(sb.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
